icache_nway: RTL

- Parametrised successor to the current direct-mapped instruction cache.
- Sits between the CPU fetch port and the block-organised instruction memory. It uses the same READ/BUSYWAIT handshake on both sides.
- Adds the following over the current cache: configurable block size, set count and associativity (1 or 2 ways), LRU replacement, a synchronous flush, and saturating hit/miss performance counters.
- Default parameters reproduce the current geometry: 8 sets, 4-word blocks, direct-mapped.

---
 rtl/icache_nway.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/icache_nway.sv
// Instruction cache with configurable block size, set count and 1/2-way LRU associativity.
// It also provides a synchronous flush and saturating hit/miss counters.
module icache_nway #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned WORDS   = 4,
    parameter int unsigned SETS    = 8,
    parameter int unsigned WAYS    = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                               CLK,
    input  logic                               RESET,
    input  logic                               READ,
    input  logic [ADDR_W-1:0]                  ADDRESS,
    output logic [INSTR_W-1:0]                 INSTRUCTION,
    output logic                               BUSYWAIT,
    output logic                               MEM_READ,
    output logic [ADDR_W-$clog2(WORDS)-1:0]    MEM_ADDRESS,
    input  logic [INSTR_W*WORDS-1:0]           MEM_READDATA,
    input  logic                               MEM_BUSYWAIT,
    input  logic                               FLUSH,
    input  logic                               CNT_CLR,
    output logic [CNT_W-1:0]                   HIT_COUNT,
    output logic [CNT_W-1:0]                   MISS_COUNT
);
    localparam int unsigned OFF_W = $clog2(WORDS);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned BA_W  = ADDR_W - OFF_W;
    localparam int unsigned TAG_W = BA_W - IDX_W;
    localparam int unsigned BLK_W = INSTR_W * WORDS;

    typedef enum logic [1:0] {IDLE, MISS, FILL} state_t;

    state_t state_q, state_d;

    logic [SETS-1:0]    valid_q [2];
    logic [TAG_W-1:0]   tag_q   [2][SETS];
    logic [BLK_W-1:0]   data_q  [2][SETS];
    logic [SETS-1:0]    lru_q;
    logic [BA_W-1:0]    mem_addr_q;
    logic               victim_q;
    logic [BLK_W-1:0]   fill_q;
    logic               flush_pend_q;
    logic [CNT_W-1:0]   hit_q, miss_q;

    logic [BA_W-1:0]    blk;
    logic [IDX_W-1:0]   idx, fill_idx;
    logic [TAG_W-1:0]   tag, fill_tag;
    int unsigned        off;
    logic               hit0, hit1, hit, miss, victim_c;
    logic [BLK_W-1:0]   hit_line;
    logic [INSTR_W-1:0] word;

    assign blk      = ADDRESS[ADDR_W-1:OFF_W];
    assign idx      = blk[IDX_W-1:0];
    assign tag      = blk[BA_W-1:IDX_W];
    assign off      = 32'(ADDRESS) % WORDS;
    assign fill_idx = mem_addr_q[IDX_W-1:0];
    assign fill_tag = mem_addr_q[BA_W-1:IDX_W];

    assign hit0     = valid_q[0][idx] && (tag_q[0][idx] == tag);
    assign hit1     = (WAYS == 2) && valid_q[1][idx] && (tag_q[1][idx] == tag);
    assign hit      = READ && (hit0 || hit1);
    assign miss     = READ && !hit;
    assign hit_line = hit1 ? data_q[1][idx] : data_q[0][idx];

    // Offset word of the hitting line
    always_comb begin
        word = '0;
        for (int unsigned w = 0; w < WORDS; w++) begin
            if (w == off) word = hit_line[w*INSTR_W +: INSTR_W];
        end
    end

    // Victim: first invalid way, else the LRU way
    always_comb begin
        victim_c = 1'b0;
        if (WAYS == 2 && valid_q[0][idx]) begin
            victim_c = valid_q[1][idx] ? lru_q[idx] : 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!FLUSH && miss) state_d = MISS;
            MISS:    if (!MEM_BUSYWAIT) state_d = FILL;
            FILL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset forces the CPU-facing outputs low without waiting for an edge
    always_comb begin
        INSTRUCTION = '0;
        BUSYWAIT    = 1'b0;
        MEM_READ    = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit) INSTRUCTION = word;
                BUSYWAIT = miss;
            end
            MISS: begin
                MEM_READ = 1'b1;
                BUSYWAIT = 1'b1;
            end
            FILL:    BUSYWAIT = 1'b1;
            default: BUSYWAIT = 1'b0;
        endcase
        if (!RESET) begin
            INSTRUCTION = '0;
            BUSYWAIT    = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_q[0]   <= '0;
            valid_q[1]   <= '0;
            lru_q        <= '0;
            mem_addr_q   <= '0;
            victim_q     <= 1'b0;
            fill_q       <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (FLUSH) begin
                        valid_q[0] <= '0;
                        valid_q[1] <= '0;
                        lru_q      <= '0;
                    end else begin
                        if (hit && WAYS == 2) lru_q[idx] <= hit0;
                        if (miss) begin
                            mem_addr_q <= blk;
                            victim_q   <= victim_c;
                        end
                    end
                end
                MISS: begin
                    if (FLUSH) flush_pend_q <= 1'b1;
                    if (!MEM_BUSYWAIT) fill_q <= MEM_READDATA;
                end
                FILL: begin
                    if (flush_pend_q || FLUSH) begin
                        valid_q[0] <= '0;
                        valid_q[1] <= '0;
                        lru_q      <= '0;
                    end else begin
                        valid_q[victim_q][fill_idx] <= 1'b1;
                        lru_q[fill_idx]             <= !victim_q;
                    end
                    flush_pend_q <= 1'b0;
                end
                default: flush_pend_q <= 1'b0;
            endcase
        end
    end

    // Line payload storage; only valid bits need reset
    always_ff @(posedge CLK) begin
        if (state_q == FILL) begin
            tag_q[victim_q][fill_idx]  <= fill_tag;
            data_q[victim_q][fill_idx] <= fill_q;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (CNT_CLR) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (state_q == IDLE) begin
            if (hit && hit_q != '1)              hit_q  <= hit_q + CNT_W'(1);
            if (miss && !FLUSH && miss_q != '1)  miss_q <= miss_q + CNT_W'(1);
        end
    end

    assign MEM_ADDRESS = mem_addr_q;
    assign HIT_COUNT   = hit_q;
    assign MISS_COUNT  = miss_q;
endmodule
